reg_dump_reader: RTL

Debug read-out engine for the 64-bit, 32-entry register file. It owns one combinational read port of the register file, driving the read address and sampling read data. It sweeps a programmed register range and streams each value out over a valid/ready interface to the lab's debug/trace sink. It sits beside the datapath and only reads, so it never drives write enable or write data.

---
 rtl/reg_dump_reader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: sweeps a register-file index range through one read port
// and streams each value over valid/ready. Optional trailing checksum beat via DUMP_CHECKSUM_EN.
module reg_dump_reader #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] firstReg,
  input  logic [ADDR_W-1:0] lastReg,
  output logic [ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0] readData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [ADDR_W-1:0] outIdx,
  output logic              outLast,
  output logic              busy,
  output logic              done
);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0] r_last, w_last_nxt;
  logic [ADDR_W-1:0] r_rs, w_rs_nxt;
  logic              r_valid, w_valid_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic              r_olast, w_olast_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_hs;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum, w_sum_nxt;
`endif

  assign w_hs = r_valid && outReady;

  // Next-state and next-value logic for the sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_last_nxt  = r_last;
    w_rs_nxt    = r_rs;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_olast_nxt = r_olast;
`ifdef DUMP_CHECKSUM_EN
    w_sum_nxt   = r_sum;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_rs_nxt = '0;
        if (start) begin
          w_ptr_nxt   = firstReg;
          w_last_nxt  = lastReg;
          w_rs_nxt    = firstReg;
`ifdef DUMP_CHECKSUM_EN
          w_sum_nxt   = '0;
`endif
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_data_nxt  = readData;
        w_idx_nxt   = r_ptr;
        w_valid_nxt = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        w_olast_nxt = 1'b0;
        w_sum_nxt   = r_sum + readData;
`else
        w_olast_nxt = (r_ptr == r_last);
`endif
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          if (r_ptr != r_last) begin
            w_ptr_nxt   = r_ptr + ADDR_W'(1);
            w_rs_nxt    = r_ptr + ADDR_W'(1);
            w_state_nxt = S_READ;
          end else begin
            w_rs_nxt    = '0;
`ifdef DUMP_CHECKSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      // Present the checksum beat once, then hold it until accepted.
      S_CSUM: begin
        if (!r_valid) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = r_sum;
          w_idx_nxt   = '0;
          w_olast_nxt = 1'b1;
        end else if (w_hs) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_DONE;
        end
      end
`endif
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; busy/done are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_last  <= '0;
      r_rs    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_olast <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_last  <= w_last_nxt;
      r_rs    <= w_rs_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_olast <= w_olast_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
`ifdef DUMP_CHECKSUM_EN
      r_sum   <= w_sum_nxt;
`endif
    end
  end

  assign rs       = r_rs;
  assign outValid = r_valid;
  assign outData  = r_data;
  assign outIdx   = r_idx;
  assign outLast  = r_olast;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
